// File: rtl/seq_bit_serializer_pkg.sv
// Shared types and constants for the sequence-detector serializer front end.
package seq_bit_serializer_pkg;

  // Serializer FSM state encoding.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } ser_state_t;

  // Line level driven while no word is in flight; must not look like a leading '1'.
  localparam logic IDLE_BIT_DEFAULT = 1'b0;

  // Bit-counter width for a given word width.
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/seq_bit_serializer_bit_counter.sv
// WIDTH-modulo bit counter with synchronous load-to-zero and a terminal-count flag.
module ser_bit_counter
  import seq_bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);

  localparam int unsigned CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_tc;

  // Terminal count marks the last bit of the current word.
  assign w_tc = (r_cnt == LAST);
  assign o_tc = w_tc;

  // Count bits; load restarts a word, wrap keeps non-power-of-two widths modulo WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_tc ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end: valid/ready word in, one bit per clock out.
module seq_bit_serializer
  import seq_bit_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter logic        IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             frame_done
);

  ser_state_t       r_state;
  ser_state_t       w_state_nxt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] w_shreg_nxt;
  logic [WIDTH-1:0] w_shreg_shift;
  logic             r_frame_done;
  logic             w_frame_done_nxt;
  logic             w_tc;
  logic             w_accept;
  logic             w_cnt_load;
  logic             w_cnt_en;

  // Bit position within the current word.
  ser_bit_counter #(
    .WIDTH (WIDTH)
  ) u_bit_counter (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_cnt_load),
    .i_en   (w_cnt_en),
    .o_tc   (w_tc)
  );

  // Ready in IDLE, or on the last bit so the next word follows with no gap.
  assign din_ready = (r_state == S_IDLE) | ((r_state == S_SHIFT) & w_tc);
  assign w_accept  = din_valid & din_ready;

  // Shift direction fixed by MSB_FIRST; vacated bit is filled with zero.
  always_comb begin
    w_shreg_shift = '0;
    if (MSB_FIRST) begin
      w_shreg_shift = {r_shreg[WIDTH-2:0], 1'b0};
    end else begin
      w_shreg_shift = {1'b0, r_shreg[WIDTH-1:1]};
    end
  end

  // Next-state, shift-register and counter control.
  always_comb begin
    w_state_nxt      = r_state;
    w_shreg_nxt      = r_shreg;
    w_cnt_load       = 1'b0;
    w_cnt_en         = 1'b0;
    w_frame_done_nxt = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_SHIFT;
          w_shreg_nxt = din;
          w_cnt_load  = 1'b1;
        end
      end
      S_SHIFT: begin
        w_frame_done_nxt = w_tc;
        if (w_accept) begin
          w_shreg_nxt = din;
          w_cnt_load  = 1'b1;
        end else begin
          w_shreg_nxt = w_shreg_shift;
          w_cnt_en    = 1'b1;
          if (w_tc) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, data and frame-done registers; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_shreg      <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shreg      <= w_shreg_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  // Serial line: current head bit while shifting, idle fill otherwise.
  always_comb begin
    sout = IDLE_BIT;
    if (r_state == S_SHIFT) begin
      sout = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
    end
  end

  assign sout_valid = (r_state == S_SHIFT);
  assign busy       = (r_state == S_SHIFT);
  assign frame_done = r_frame_done;

endmodule
